// File: rtl/ets_phase_stepper_pkg.sv
// ets_phase_stepper_pkg: shared state encodings and capture constants for the ETS sampler/stepper pair.
package ets_phase_stepper_pkg;
  localparam int ETS_POS_W = 16;
  localparam int ETS_MAX_COUNT = 560;
  localparam int CNT_W = 16;
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ISSUE  = 4'd1,
    ST_WAITD  = 4'd2,
    ST_SETTLE = 4'd3,
    ST_ACK    = 4'd4
  } state_e;
endpackage

// File: rtl/ets_phase_stepper.sv
// ets_phase_stepper: turns shift/rewind requests into MMCM fine-phase step bursts and tracks absolute phase.
module ets_phase_stepper
  import ets_phase_stepper_pkg::*;
#(
  parameter int POS_W = ETS_POS_W,
  parameter int POS_MAX = 4095,
  parameter int SETTLE_CYCLES = 16,
  parameter int PS_TIMEOUT = 1023
) (
  input  logic             sample_clk,
  input  logic             reset,
  input  logic             shift,
  output logic             shift_done,
  input  logic             rewind,
  output logic             rewind_done,
  input  logic [7:0]       steps_cfg,
  output logic             ps_en,
  output logic             ps_incdec,
  input  logic             ps_done,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             error
);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(PS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  state_e state_q, state_d;
  logic dir_q, dir_d, pend_s_q, pend_s_d, pend_r_q, pend_r_d, err_q, err_d, take_s, take_r;
  logic [POS_W-1:0] pos_q, pos_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    take_s   = (state_q == ST_IDLE) && (shift || pend_s_q);
    take_r   = (state_q == ST_IDLE) && !take_s && (rewind || pend_r_q);
    pend_s_d = take_s ? (shift && pend_s_q) : (shift || pend_s_q);
    pend_r_d = take_r ? (rewind && pend_r_q) : (rewind || pend_r_q);
    err_d    = err_q || (!take_s && shift && pend_s_q) || (!take_r && rewind && pend_r_q);
    case (state_q)
      ST_IDLE:
        if (take_s) begin
          dir_d   = 1'b1;
          rem_d   = (steps_cfg == 8'd0) ? POS_ONE : POS_W'(steps_cfg);
          state_d = ST_ISSUE;
        end else if (take_r) begin
          dir_d   = 1'b0;
          rem_d   = pos_q;
          state_d = (pos_q == '0) ? ST_ACK : ST_ISSUE;
        end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAITD;
      end
      ST_WAITD:
        if (ps_done) begin
          pos_d   = dir_q ? ((pos_q == POS_LAST) ? '0 : pos_q + POS_ONE)
                          : ((pos_q == '0) ? POS_LAST : pos_q - POS_ONE);
          rem_d   = rem_q - POS_ONE;
          cnt_d   = '0;
          state_d = (rem_q == POS_ONE) ? ST_SETTLE : ST_ISSUE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      ST_SETTLE:
        if (cnt_q >= SETTLE_LAST) state_d = ST_ACK;
        else cnt_d = cnt_q + CNT_ONE;
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ps_en       = state_q == ST_ISSUE;
    ps_incdec   = (state_q == ST_ISSUE) && dir_q;
    shift_done  = (state_q == ST_ACK) && dir_q;
    rewind_done = (state_q == ST_ACK) && !dir_q;
    busy        = state_q != ST_IDLE;
    error       = err_q;
    position    = pos_q;
  end
endmodule

// File: tb/tb_ets_phase_stepper.sv
// tb_ets_phase_stepper: directed bench with a procedural burst model checked every cycle.
module tb_ets_phase_stepper;
  import ets_phase_stepper_pkg::*;
  localparam int POS_MAX = 4095;
  localparam int SETTLE = 16;
  localparam int TMO = 1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, shift = 1'b0, rewind = 1'b0, ps_done = 1'b0;
  logic [7:0] steps_cfg = 8'd0;
  logic shift_done, rewind_done, ps_en, ps_incdec, busy, error;
  logic [15:0] position;

  logic s0_shift = 1'b0, s0_pd = 1'b0;
  logic s0_sd, s0_rd, s0_psen, s0_incdec, s0_busy, s0_err;
  logic [15:0] s0_pos;

  ets_phase_stepper #(.POS_W(16), .POS_MAX(POS_MAX), .SETTLE_CYCLES(SETTLE), .PS_TIMEOUT(TMO)) dut (
    .sample_clk(clk), .reset(reset), .shift(shift), .shift_done(shift_done),
    .rewind(rewind), .rewind_done(rewind_done), .steps_cfg(steps_cfg), .ps_en(ps_en),
    .ps_incdec(ps_incdec), .ps_done(ps_done), .position(position), .busy(busy), .error(error)
  );

  ets_phase_stepper #(.POS_W(16), .POS_MAX(POS_MAX), .SETTLE_CYCLES(0), .PS_TIMEOUT(TMO)) dut0 (
    .sample_clk(clk), .reset(reset), .shift(s0_shift), .shift_done(s0_sd),
    .rewind(1'b0), .rewind_done(s0_rd), .steps_cfg(8'd1), .ps_en(s0_psen),
    .ps_incdec(s0_incdec), .ps_done(s0_pd), .position(s0_pos), .busy(s0_busy), .error(s0_err)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // MMCM stand-in: answers each ps_en with ps_done ps_dly cycles later (0 = never answers)
  int ps_dly = 1, pend = 0, pd_cyc = 0, stray_req = 0, stray_ack = 0;
  always @(negedge clk) begin
    ps_done = 1'b0;
    if (reset) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ps_done = 1'b1;
          pd_cyc = cyc;
        end
      end
      if (stray_req != stray_ack) begin
        ps_done = 1'b1;
        stray_ack = stray_req;
      end
      if (ps_en && ps_dly > 0) pend = ps_dly;
    end
  end

  int pe_inc = 0, pe_dec = 0, sd_n = 0, rd_n = 0;
  always @(negedge clk) begin
    if (ps_en) begin
      if (ps_incdec) pe_inc++;
      else pe_dec++;
    end
    if (shift_done) sd_n++;
    if (rewind_done) rd_n++;
  end

  int m_pos = 0, m_cfg = 0, pend_s = 0, pend_r = 0;
  bit m_err = 0, m_pd = 0, ab = 0, chk_en = 0;
  bit e_psen = 0, e_incdec = 0, e_sd = 0, e_rd = 0, e_busy = 0;

  task automatic set_idle();
    e_psen = 0; e_incdec = 0; e_sd = 0; e_rd = 0; e_busy = 0;
  endtask

  // one clock edge of the model: request bookkeeping, reset and ps_done sampling
  task automatic step(input bit idle, output int kind);
    int ns, nr;
    @(posedge clk);
    kind = 0;
    ab = 0;
    if (reset) begin
      m_pos = 0; m_err = 0; pend_s = 0; pend_r = 0; ab = 1;
      set_idle();
      return;
    end
    m_cfg = int'(steps_cfg);
    m_pd = ps_done;
    ns = pend_s + int'(shift);
    nr = pend_r + int'(rewind);
    if (idle && ns > 0) begin kind = 1; ns--; end
    else if (idle && nr > 0) begin kind = 2; nr--; end
    if (ns > 1) begin m_err = 1; ns = 1; end
    if (nr > 1) begin m_err = 1; nr = 1; end
    pend_s = ns;
    pend_r = nr;
  endtask

  initial begin : model
    int kind, n, w;
    bit inc, to;
    forever begin
      step(1'b1, kind);
      if (ab || kind == 0) begin set_idle(); continue; end
      inc = kind == 1;
      n = inc ? (m_cfg == 0 ? 1 : m_cfg) : m_pos;
      e_busy = 1;
      to = 0;
      for (int i = 0; i < n && !to && !ab; i++) begin
        e_psen = 1; e_incdec = inc;
        step(1'b0, kind);
        e_psen = 0; e_incdec = 0;
        w = 0;
        while (!ab && !to) begin
          step(1'b0, kind);
          if (ab) break;
          if (m_pd) begin
            m_pos = inc ? (m_pos + 1) % (POS_MAX + 1) : (m_pos + POS_MAX) % (POS_MAX + 1);
            break;
          end
          w++;
          if (w == TMO) begin m_err = 1; to = 1; end
        end
      end
      if (!ab && n > 0) for (int j = 0; j <= SETTLE && !ab; j++) step(1'b0, kind);
      if (!ab) begin
        e_sd = inc; e_rd = !inc;
        step(1'b0, kind);
      end
      set_idle();
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      cmp("ps_en", ps_en, e_psen);
      if (e_psen) cmp("ps_incdec", ps_incdec, e_incdec);
      cmp("shift_done", shift_done, e_sd);
      cmp("rewind_done", rewind_done, e_rd);
      cmp("busy", busy, e_busy);
      cmp("error", error, m_err);
      cmp("position", position, m_pos);
    end
  end

  task automatic pulse(input bit s, input bit r, input int n, output int t);
    @(negedge clk);
    steps_cfg = n[7:0]; shift = s; rewind = r; t = cyc;
    @(negedge clk);
    shift = 0; rewind = 0;
  endtask

  task automatic wait_done(input bit is_shift, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (is_shift ? shift_done : rewind_done) begin at = cyc; break; end
      @(negedge clk);
    end
    if (at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_%s: no done pulse within %0d cycles", is_shift ? "shift_done" : "rewind_done", budget);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int t, at, at2, b0, b1, b2, b3;
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;
    sync();
    cmp("reset_position", position, 0);
    cmp("reset_busy", busy, 0);
    cmp("reset_error", error, 0);
    // minimum latency on the zero-settle instance, ps_done one cycle after ps_en
    @(negedge clk); s0_shift = 1; t = cyc;
    @(negedge clk); s0_shift = 0;
    cmp("min_psen_at_1", s0_psen, 1);
    cmp("min_incdec", s0_incdec, 1);
    @(negedge clk); s0_pd = 1;
    cmp("min_busy", s0_busy, 1);
    @(negedge clk); s0_pd = 0;
    cmp("min_no_done_at_3", s0_sd, 0);
    @(negedge clk);
    cmp("min_done_at_4", s0_sd, 1);
    cmp("min_latency", cyc - t, 4);
    @(negedge clk);
    cmp("min_position", s0_pos, 1);
    cmp("min_flags", {s0_rd, s0_err, s0_busy}, 0);
    // one step with 16 settle cycles
    pulse(1, 0, 1, t);
    wait_done(1, 100, at);
    cmp("t1_latency", at - t, 20);
    sync();
    cmp("t1_position", position, 1);
    // four steps, ps_done delay 3
    ps_dly = 3;
    b0 = pe_inc;
    pulse(1, 0, 4, t);
    wait_done(1, 200, at);
    cmp("t2_done_after_last_psdone", at - pd_cyc, 18);
    sync();
    cmp("t2_psen_count", pe_inc - b0, 4);
    cmp("t2_position", position, 5);
    ps_dly = 1;
    pulse(0, 1, 0, t);
    wait_done(0, 200, at);
    sync();
    cmp("t2_rewind_position", position, 0);
    // full capture then rewind
    b0 = pe_inc; b1 = sd_n;
    for (int k = 0; k < ETS_MAX_COUNT; k++) begin
      pulse(1, 0, 7, t);
      wait_done(1, 200, at);
    end
    sync();
    cmp("t3_position", position, 3920);
    cmp("t3_inc_steps", pe_inc - b0, 3920);
    cmp("t3_shift_dones", sd_n - b1, 560);
    b0 = pe_dec; b1 = sd_n; b2 = rd_n; b3 = pe_inc;
    pulse(0, 1, 0, t);
    wait_done(0, 9000, at);
    repeat (3) @(negedge clk);
    sync();
    cmp("t3_dec_steps", pe_dec - b0, 3920);
    cmp("t3_no_inc_steps", pe_inc - b3, 0);
    cmp("t3_no_shift_done", sd_n - b1, 0);
    cmp("t3_one_rewind_done", rd_n - b2, 1);
    cmp("t3_rewound", position, 0);
    // wrap past POS_MAX, then rewind from zero
    for (int k = 0; k < 16; k++) begin
      pulse(1, 0, 255, t);
      wait_done(1, 700, at);
    end
    pulse(1, 0, 15, t);
    wait_done(1, 100, at);
    sync();
    cmp("t4_at_max", position, 4095);
    pulse(1, 0, 2, t);
    wait_done(1, 100, at);
    sync();
    cmp("t4_wrapped", position, 1);
    pulse(0, 1, 0, t);
    wait_done(0, 100, at);
    sync();
    cmp("t4_back_to_zero", position, 0);
    b0 = pe_inc + pe_dec;
    pulse(0, 1, 0, t);
    wait_done(0, 5, at);
    cmp("t4_rewind_zero_latency", at - t, 1);
    sync();
    cmp("t4_rewind_zero_no_psen", pe_inc + pe_dec - b0, 0);
    // simultaneous shift and rewind
    b0 = pe_dec; b1 = pe_inc;
    pulse(1, 1, 3, t);
    wait_done(1, 200, at);
    @(negedge clk);
    wait_done(0, 200, at2);
    cmp("t6_shift_first", at2 > at, 1);
    sync();
    cmp("t6_inc_steps", pe_inc - b1, 3);
    cmp("t6_dec_steps", pe_dec - b0, 3);
    cmp("t6_position", position, 0);
    // ps_done never arrives
    ps_dly = 0;
    pulse(1, 0, 1, t);
    wait_done(1, 1200, at);
    cmp("t5_timeout_latency", at - t, 1042);
    sync();
    cmp("t5_error", error, 1);
    cmp("t5_position", position, 0);
    repeat (20) @(negedge clk);
    sync();
    cmp("t5_error_sticky", error, 1);
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk); reset = 0;
    sync();
    cmp("reset_clears_error", error, 0);
    // request overrun while busy
    ps_dly = 1;
    pulse(1, 0, 2, t);
    pulse(1, 0, 1, t);
    pulse(1, 0, 1, t);
    wait_done(1, 200, at);
    @(negedge clk);
    wait_done(1, 200, at);
    sync();
    cmp("overrun_error", error, 1);
    cmp("overrun_position", position, 3);
    // stray ps_done while idle
    @(posedge clk); stray_req++;
    repeat (3) @(negedge clk);
    sync();
    cmp("stray_psdone_ignored", position, 3);
    // reset in the middle of a burst
    ps_dly = 0;
    pulse(1, 0, 1, t);
    repeat (5) @(negedge clk);
    sync();
    cmp("midburst_busy", busy, 1);
    b0 = sd_n; b1 = rd_n;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    sync();
    cmp("abort_busy", busy, 0);
    cmp("abort_position", position, 0);
    repeat (30) @(negedge clk);
    sync();
    cmp("abort_no_done", (sd_n - b0) + (rd_n - b1), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
